// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous in-order buffer of fetched instructions with flush.
//               Flush wins over push and pop; a pop of an empty buffer is a no-op.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_entry_t    r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_pop;
   logic            w_do_push;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front-end. Owns the fetch PC, issues at most
//               one request at a time to a variable-latency instruction memory,
//               buffers returned words and squashes stale work on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [31:0]   imem_addr,
   input  logic          imem_ack,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic          instr_valid,
   output logic [31:0]   Instr,
   output logic [31:0]   instr_pc,
   input  logic          instr_ready,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     w_fetch_pc_next;
   logic [31:0]     r_addr;
   logic            r_drop;
   logic            w_drop_next;
   logic [31:0]     w_redirect_target;
   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic            w_full;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_count_next;
   logic            w_free;
   fetch_entry_t    w_head;
   fetch_entry_t    w_wdata;

   assign w_redirect_target = {redirect_pc[31:2], 2'b00};
   assign w_pop             = instr_ready && !w_empty;
   // A response is only ever requested when its slot is reserved, so the
   // full guard merely mirrors the buffer's own protection.
   assign w_push            = (r_state == WAIT) && imem_rvalid && !r_drop && !redirect
                              && !(w_full && !w_pop);
   assign w_wdata.pc        = r_addr;
   assign w_wdata.instr     = imem_rdata;

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = r_addr;
   assign instr_valid = !w_empty;
   assign Instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

   // Occupancy after this cycle's push/pop; a redirect empties the buffer.
   always_comb begin
      w_count_next = w_count;
      if (w_push && !w_pop) begin
         w_count_next = w_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = w_count - CW'(1);
      end
      w_free = redirect || (w_count_next < CW'(BUF_DEPTH));
   end

   // Next-state, next fetch PC and drop-flag logic.
   always_comb begin
      w_state_next    = r_state;
      w_drop_next     = r_drop;
      w_fetch_pc_next = r_fetch_pc;
      if (redirect) begin
         w_fetch_pc_next = w_redirect_target;
      end
      case (r_state)
         IDLE: begin
            w_drop_next = 1'b0;
            if (w_free) begin
               w_state_next = REQ;
            end
         end
         REQ: begin
            // The request keeps its old address; its response gets discarded.
            if (redirect) begin
               w_drop_next = 1'b1;
            end
            if (imem_ack) begin
               w_state_next = WAIT;
               // A stale request must not step the already-redirected PC.
               if (!redirect && !r_drop) begin
                  w_fetch_pc_next = r_fetch_pc + 32'(INSTR_BYTES);
               end
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               // The outstanding response has landed, so nothing remains to drop.
               w_drop_next  = 1'b0;
               w_state_next = w_free ? REQ : IDLE;
            end else if (redirect) begin
               w_drop_next = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State register; the request address is latched on entry to REQ and held
   // until the matching response so it also tags the pushed word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_drop     <= w_drop_next;
         if ((w_state_next == REQ) && (r_state != REQ)) begin
            r_addr <= w_fetch_pc_next;
         end
      end
   end

   instr_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_instr_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect),
      .wdata (w_wdata),
      .rdata (w_head),
      .count (w_count),
      .empty (w_empty),
      .full  (w_full)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a behavioural
//               variable-latency instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic          clk;
   logic          reset;
   logic          instr_ready;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_ack;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          instr_valid;
   logic [31:0]   Instr;
   logic [31:0]   instr_pc;

   // second instance with a reset PC near the top of the address space
   logic          req2;
   logic [31:0]   addr2;
   logic          ack2;
   logic          rv2;
   logic [31:0]   rdata2;
   logic          valid2;
   logic [31:0]   instr2;
   logic [31:0]   pc2;

   int            checks;
   int            failures;

   int            ack_delay;
   int            rv_delay;
   int            wait_cnt;
   int            rv_cnt;
   logic          pending;
   logic [31:0]   pend_addr;

   logic          pend2;
   logic [31:0]   paddr2;
   logic [31:0]   log2 [8];
   int            n2;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .Instr       (Instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   fetch_unit #(
      .RESET_PC  (32'hFFFF_FFF8),
      .BUF_DEPTH (2)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (req2),
      .imem_addr   (addr2),
      .imem_ack    (ack2),
      .imem_rvalid (rv2),
      .imem_rdata  (rdata2),
      .instr_valid (valid2),
      .Instr       (instr2),
      .instr_pc    (pc2),
      .instr_ready (1'b1),
      .redirect    (1'b0),
      .redirect_pc (32'h0000_0000)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return ~a;
   endfunction

   // Memory for dut: ack after ack_delay request cycles, data rv_delay cycles after ack.
   always @(negedge clk) begin
      imem_ack    = 1'b0;
      imem_rvalid = 1'b0;
      if (reset) begin
         pending  = 1'b0;
         wait_cnt = 0;
         rv_cnt   = 0;
         imem_rdata = 32'h0;
      end else if (pending) begin
         if (rv_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_addr);
            pending     = 1'b0;
         end else begin
            rv_cnt = rv_cnt - 1;
         end
      end else if (imem_req) begin
         if (wait_cnt >= ack_delay) begin
            imem_ack  = 1'b1;
            pending   = 1'b1;
            pend_addr = imem_addr;
            rv_cnt    = rv_delay - 1;
            wait_cnt  = 0;
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end
   end

   // Zero-wait memory for dut2, logging every accepted address.
   always @(negedge clk) begin
      ack2 = 1'b0;
      rv2  = 1'b0;
      if (reset) begin
         pend2  = 1'b0;
         n2     = 0;
         rdata2 = 32'h0;
      end else if (pend2) begin
         rv2    = 1'b1;
         rdata2 = word_of(paddr2);
         pend2  = 1'b0;
      end else if (req2) begin
         ack2   = 1'b1;
         pend2  = 1'b1;
         paddr2 = addr2;
         if (n2 < 8) begin
            log2[n2] = addr2;
         end
         n2 = n2 + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      ack_delay   = 0;
      rv_delay    = 1;
      repeat (3) tick();

      // reset state
      check("rst_req",    32'(imem_req), 32'd0);
      check("rst_valid",  32'(instr_valid), 32'd0);
      check("rst_instr",  Instr, 32'h0);
      check("rst_pc",     instr_pc, 32'h0);
      check("rst_addr",   imem_addr, 32'h0);
      check("rst_addr2",  addr2, 32'hFFFF_FFF8);

      // zero-wait streaming, ready=1
      reset = 1'b0;
      tick();
      check("s_req1",   32'(imem_req), 32'd1);
      check("s_addr1",  imem_addr, 32'h0);
      tick();
      check("s_wait_req",   32'(imem_req), 32'd0);
      check("s_wait_valid", 32'(instr_valid), 32'd0);
      tick();
      check("s_valid0", 32'(instr_valid), 32'd1);
      check("s_pc0",    instr_pc, 32'h0);
      check("s_instr0", Instr, word_of(32'h0));
      check("s_req2",   32'(imem_req), 32'd1);
      check("s_addr2",  imem_addr, 32'h4);
      tick();
      check("s_drained", 32'(instr_valid), 32'd0);
      tick();
      check("s_valid1", 32'(instr_valid), 32'd1);
      check("s_pc1",    instr_pc, 32'h4);
      check("s_instr1", Instr, word_of(32'h4));
      check("s_addr3",  imem_addr, 32'h8);

      // back-pressure: buffer fills, requests stop
      instr_ready = 1'b0;
      tick();
      check("bp_wait_req", 32'(imem_req), 32'd0);
      tick();
      check("bp_full_req", 32'(imem_req), 32'd0);
      check("bp_head",     instr_pc, 32'h4);
      repeat (3) tick();
      check("bp_hold_req",  32'(imem_req), 32'd0);
      check("bp_hold_head", instr_pc, 32'h4);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("bp_one_req",  32'(imem_req), 32'd1);
      check("bp_one_addr", imem_addr, 32'hC);
      check("bp_new_head", instr_pc, 32'h8);
      tick();
      tick();
      check("bp_refull_req", 32'(imem_req), 32'd0);
      repeat (2) tick();
      check("bp_stay_req", 32'(imem_req), 32'd0);
      check("bp_stay_pc",  instr_pc, 32'h8);

      // redirect during a long wait drops the stale word
      reset       = 1'b1;
      instr_ready = 1'b1;
      rv_delay    = 5;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rw_req",  32'(imem_req), 32'd1);
      check("rw_addr", imem_addr, 32'h0);
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      check("rw_req_a",   32'(imem_req), 32'd0);
      check("rw_valid_a", 32'(instr_valid), 32'd0);
      tick();
      check("rw_req_b", 32'(imem_req), 32'd0);
      tick();
      rv_delay = 1;
      check("rw_valid_b", 32'(instr_valid), 32'd0);
      tick();
      check("rw_new_req",   32'(imem_req), 32'd1);
      check("rw_new_addr",  imem_addr, 32'h100);
      check("rw_dropped",   32'(instr_valid), 32'd0);
      tick();
      tick();
      check("rw_valid", 32'(instr_valid), 32'd1);
      check("rw_pc",    instr_pc, 32'h100);
      check("rw_instr", Instr, word_of(32'h100));

      // redirect while the memory withholds ack
      reset     = 1'b1;
      ack_delay = 4;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("ra_req1", 32'(imem_req), 32'd1);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      check("ra_addr2", imem_addr, 32'h0);
      tick();
      redirect = 1'b0;
      check("ra_req3",  32'(imem_req), 32'd1);
      check("ra_addr3", imem_addr, 32'h0);
      tick();
      check("ra_addr4", imem_addr, 32'h0);
      tick();
      check("ra_req5",  32'(imem_req), 32'd1);
      check("ra_addr5", imem_addr, 32'h0);
      tick();
      ack_delay = 0;
      check("ra_wait_req",   32'(imem_req), 32'd0);
      check("ra_wait_valid", 32'(instr_valid), 32'd0);
      tick();
      check("ra_new_req",  32'(imem_req), 32'd1);
      check("ra_new_addr", imem_addr, 32'h200);
      check("ra_dropped",  32'(instr_valid), 32'd0);
      tick();
      check("ra_dropped2", 32'(instr_valid), 32'd0);
      tick();
      check("ra_valid",     32'(instr_valid), 32'd1);
      check("ra_pc",        instr_pc, 32'h200);
      check("ra_instr",     Instr, word_of(32'h200));
      check("ra_next_addr", imem_addr, 32'h204);

      // reset with one buffered entry and a request outstanding
      instr_ready = 1'b0;
      tick();
      check("mr_pre_valid", 32'(instr_valid), 32'd1);
      check("mr_pre_pc",    instr_pc, 32'h200);
      check("mr_pre_req",   32'(imem_req), 32'd0);
      reset = 1'b1;
      tick();
      check("mr_valid", 32'(instr_valid), 32'd0);
      check("mr_req",   32'(imem_req), 32'd0);
      check("mr_addr",  imem_addr, 32'h0);
      reset       = 1'b0;
      instr_ready = 1'b1;
      tick();
      check("mr_restart_req",  32'(imem_req), 32'd1);
      check("mr_restart_addr", imem_addr, 32'h0);
      tick();
      tick();
      check("mr_first_pc", instr_pc, 32'h0);

      // address wrap in the high-reset-PC instance
      repeat (4) tick();
      check("wrap_count", 32'(n2 >= 3), 32'd1);
      check("wrap_a0",    log2[0], 32'hFFFF_FFF8);
      check("wrap_a1",    log2[1], 32'hFFFF_FFFC);
      check("wrap_a2",    log2[2], 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
